time_set_controller: RTL and testbench

Sequences manual time-setting for the digital clock. Captures the running hours/minutes/seconds, steps the user through editing each field, and increments the selected field with wrap-around. Supports auto-repeat while the increment button is held. Commits the edited values to the timekeeping counters with a single load pulse. Sits between the debounced button inputs and the hours/minutes/seconds counter chain.

---
 rtl/time_set_pkg.sv | 21 ++
 rtl/time_set_controller_btn_repeat.sv | 55 +++++
 rtl/time_set_controller.sv | 148 ++++++++++++++
 tb/tb_time_set_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the manual time-setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  localparam logic [1:0] SEL_HOURS   = 2'b10;
  localparam logic [1:0] SEL_MINUTES = 2'b01;
  localparam logic [1:0] SEL_SECONDS = 2'b00;
  localparam logic [1:0] SEL_NONE    = 2'b11;

  localparam logic [5:0] HOURS_MAX   = 6'd23;
  localparam logic [5:0] MIN_SEC_MAX = 6'd59;

  // One step up or down with wrap-around between 0 and vmax.
  function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] vmax,
                                        input logic up);
    if (up) return (v >= vmax) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_btn_repeat.sv
// Button edge detect with hold-to-repeat: one event on the edge, then after
// REPEAT_DELAY cycles (from input rise) and every REPEAT_PERIOD thereafter.
module btn_repeat #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_btn,
  input  logic i_arm,
  output logic o_edge,
  output logic o_event
);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  logic          r_q, r_d, r_held, r_rep;
  logic [CW-1:0] r_cnt;
  logic          w_fire;

  assign o_edge  = r_q & ~r_d;
  // Edge event is one cycle after input rise, so the first repeat is DELAY-1 after it.
  assign w_fire  = r_held & r_q & (r_rep ? (r_cnt == CW'(REPEAT_PERIOD))
                                         : (r_cnt == CW'(REPEAT_DELAY - 1)));
  assign o_event = (o_edge & i_arm) | w_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= 1'b0;
      r_d    <= 1'b0;
      r_held <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_q <= i_btn;
      r_d <= r_q;
      if (!r_q) begin
        r_held <= 1'b0;
        r_rep  <= 1'b0;
        r_cnt  <= '0;
      end else if (o_edge) begin
        // A press that starts while disarmed never repeats.
        r_held <= i_arm;
        r_rep  <= 1'b0;
        r_cnt  <= CW'(1);
      end else if (w_fire) begin
        r_rep <= 1'b1;
        r_cnt <= CW'(1);
      end else if (r_held) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Manual time-set sequencer: RUN -> EDIT_H -> EDIT_M -> EDIT_S -> COMMIT.
// Define DEC_BUTTON_EN to add a dec_btn input that steps the field downward.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       set_btn,
  input  logic       inc_btn,
`ifdef DEC_BUTTON_EN
  input  logic       dec_btn,
`endif
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  output logic [1:0] select,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_h,
  output logic [5:0] load_m,
  output logic [5:0] load_s,
  output logic       blink
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        r_state, w_next;
  logic          r_set_q, r_set_d, w_set_edge;
  logic          w_edit, w_next_edit;
  logic          w_inc_ev, w_inc_edge;
  logic          w_up, w_req, w_btn_ev, w_any_edge, w_step, w_timeout;
  logic [4:0]    r_eh;
  logic [5:0]    r_em, r_es;
  logic [5:0]    w_h_nx, w_m_nx, w_s_nx;
  logic [TW-1:0] r_to;
  logic          r_blink;

  assign w_set_edge  = r_set_q & ~r_set_d;
  assign w_edit      = (r_state == EDIT_H) || (r_state == EDIT_M) || (r_state == EDIT_S);
  assign w_next_edit = (w_next == EDIT_H) || (w_next == EDIT_M) || (w_next == EDIT_S);

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .clock(clock), .reset_n(reset_n), .i_btn(inc_btn), .i_arm(w_edit),
    .o_edge(w_inc_edge), .o_event(w_inc_ev));

`ifdef DEC_BUTTON_EN
  logic w_dec_ev, w_dec_edge;
  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .clock(clock), .reset_n(reset_n), .i_btn(dec_btn), .i_arm(w_edit),
    .o_edge(w_dec_edge), .o_event(w_dec_ev));
  // Opposing events in one cycle cancel out.
  assign w_up       = w_inc_ev;
  assign w_req      = w_inc_ev ^ w_dec_ev;
  assign w_btn_ev   = w_inc_ev | w_dec_ev;
  assign w_any_edge = w_inc_edge | w_dec_edge;
`else
  assign w_up       = 1'b1;
  assign w_req      = w_inc_ev;
  assign w_btn_ev   = w_inc_ev;
  assign w_any_edge = w_inc_edge;
`endif

  assign w_step    = w_req & w_edit & ~w_set_edge;
  assign w_timeout = w_edit & tick_1hz & ~w_set_edge & ~w_any_edge
                   & (r_to == TW'(TIMEOUT_TICKS - 1));
  assign w_h_nx    = f_step({1'b0, r_eh}, HOURS_MAX, w_up);
  assign w_m_nx    = f_step(r_em, MIN_SEC_MAX, w_up);
  assign w_s_nx    = f_step(r_es, MIN_SEC_MAX, w_up);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:    if (w_set_edge) w_next = EDIT_H;
      EDIT_H: if (w_set_edge) w_next = EDIT_M; else if (w_timeout) w_next = RUN;
      EDIT_M: if (w_set_edge) w_next = EDIT_S; else if (w_timeout) w_next = RUN;
      EDIT_S: if (w_set_edge) w_next = COMMIT; else if (w_timeout) w_next = RUN;
      COMMIT: w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_set_q <= 1'b0;
      r_set_d <= 1'b0;
      r_eh    <= '0;
      r_em    <= '0;
      r_es    <= '0;
      load_h  <= '0;
      load_m  <= '0;
      load_s  <= '0;
      r_to    <= '0;
      r_blink <= 1'b0;
    end else begin
      r_set_q <= set_btn;
      r_set_d <= r_set_q;

      if (r_state == RUN && w_set_edge) begin
        r_eh <= ({1'b0, cur_h} > HOURS_MAX)   ? 5'd0 : cur_h;
        r_em <= (cur_m > MIN_SEC_MAX)         ? 6'd0 : cur_m;
        r_es <= (cur_s > MIN_SEC_MAX)         ? 6'd0 : cur_s;
      end else if (w_step) begin
        case (r_state)
          EDIT_H:  r_eh <= w_h_nx[4:0];
          EDIT_M:  r_em <= w_m_nx;
          default: r_es <= w_s_nx;
        endcase
      end

      if (r_state == EDIT_S && w_set_edge) begin
        load_h <= r_eh;
        load_m <= r_em;
        load_s <= r_es;
      end

      if (!w_next_edit || w_next != r_state || w_set_edge || w_any_edge) r_to <= '0;
      else if (tick_1hz)                                                r_to <= r_to + TW'(1);

      // Field shown solid on entry and right after any step, else blinks at 1 Hz.
      if (!w_next_edit || w_next != r_state || w_btn_ev) r_blink <= 1'b0;
      else if (tick_1hz)                                 r_blink <= ~r_blink;
    end
  end

  always_comb begin
    select = SEL_NONE;
    case (r_state)
      EDIT_H:  select = SEL_HOURS;
      EDIT_M:  select = SEL_MINUTES;
      EDIT_S:  select = SEL_SECONDS;
      default: select = SEL_NONE;
    endcase
  end

  assign run_en = (r_state == RUN);
  assign load   = (r_state == COMMIT);
  assign blink  = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short repeat/timeout parameters.
module tb_time_set_controller;
  logic       clock = 1'b0, reset_n = 1'b0, tick_1hz = 1'b0, set_btn = 1'b0, inc_btn = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0, cur_s = '0;
  logic [1:0] select;
  logic       run_en, load, blink;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;
  int         n_chk = 0, n_err = 0;

  time_set_controller #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TIMEOUT_TICKS(3)) dut (
    .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz), .set_btn(set_btn),
    .inc_btn(inc_btn), .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .select(select),
    .run_en(run_en), .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .blink(blink));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_set();
    cyc(1); set_btn = 1'b1; cyc(2); set_btn = 1'b0;
  endtask

  task automatic press_inc();
    cyc(1); inc_btn = 1'b1; cyc(2); inc_btn = 1'b0;
  endtask

  task automatic tick();
    cyc(1); tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_select", 32'(select), 32'd3);
    chk("rst_run_en", 32'(run_en), 32'd1);
    chk("rst_load",   32'(load),   32'd0);
    chk("rst_load_h", 32'(load_h), 32'd0);
    chk("rst_blink",  32'(blink),  32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Enter and commit unchanged 12:34:56
    cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
    press_set();
    chk("t1_sel_h",  32'(select), 32'd2);
    chk("t1_run_en", 32'(run_en), 32'd0);
    chk("t1_blink",  32'(blink),  32'd0);
    press_set();
    chk("t1_sel_m", 32'(select), 32'd1);
    press_set();
    chk("t1_sel_s", 32'(select), 32'd0);
    chk("t1_noload", 32'(load), 32'd0);
    press_set();
    chk("t1_load",   32'(load),   32'd1);
    chk("t1_load_h", 32'(load_h), 32'd12);
    chk("t1_load_m", 32'(load_m), 32'd34);
    chk("t1_load_s", 32'(load_s), 32'd56);
    cyc(1);
    chk("t1_load_off", 32'(load),   32'd0);
    chk("t1_run_back", 32'(run_en), 32'd1);
    chk("t1_sel_none", 32'(select), 32'd3);
    chk("t1_hold_h",   32'(load_h), 32'd12);

    // Wrap hours 23->0 and minutes 59->0; blink toggles on tick and clears on inc
    cur_h = 5'd23; cur_m = 6'd59; cur_s = 6'd7;
    press_set();
    tick();
    chk("t2_blink_tick", 32'(blink), 32'd1);
    press_inc();
    chk("t2_blink_inc", 32'(blink), 32'd0);
    press_set();
    press_inc();
    press_set();
    press_set();
    chk("t2_load",   32'(load),   32'd1);
    chk("t2_load_h", 32'(load_h), 32'd0);
    chk("t2_load_m", 32'(load_m), 32'd0);
    chk("t2_load_s", 32'(load_s), 32'd7);
    cyc(1);

    // Auto-repeat: 12-cycle hold gives 6 events (10->16), re-press gives 1 more
    cur_h = 5'd1; cur_m = 6'd2; cur_s = 6'd10;
    press_set(); press_set(); press_set();
    chk("t3_sel_s", 32'(select), 32'd0);
    cyc(1); inc_btn = 1'b1; cyc(12); inc_btn = 1'b0;
    cyc(2); inc_btn = 1'b1; cyc(2); inc_btn = 1'b0;
    press_set();
    chk("t3_load_h", 32'(load_h), 32'd1);
    chk("t3_load_m", 32'(load_m), 32'd2);
    chk("t3_load_s", 32'(load_s), 32'd17);
    cyc(1);

    // Hold started in RUN never generates edit events
    cur_h = 5'd5; cur_m = 6'd6; cur_s = 6'd7;
    inc_btn = 1'b1; cyc(3);
    press_set();
    cyc(8); inc_btn = 1'b0;
    press_set(); press_set(); press_set();
    chk("t3b_load_h", 32'(load_h), 32'd5);
    cyc(1);

    // Simultaneous set and inc edge in EDIT_M: set wins
    cur_h = 5'd0; cur_m = 6'd20; cur_s = 6'd0;
    press_set(); press_set();
    cyc(1); set_btn = 1'b1; inc_btn = 1'b1; cyc(2); set_btn = 1'b0; inc_btn = 1'b0;
    chk("t4_sel_s", 32'(select), 32'd0);
    press_set();
    chk("t4_load_m", 32'(load_m), 32'd20);
    cyc(1);

    // Timeout after 3 ticks returns to RUN without a load
    press_set();
    tick(); tick();
    chk("t5_still_edit", 32'(select), 32'd2);
    tick();
    chk("t5_sel_none", 32'(select), 32'd3);
    chk("t5_run_en",   32'(run_en), 32'd1);
    chk("t5_load",     32'(load),   32'd0);
    chk("t5_blink",    32'(blink),  32'd0);
    chk("t5_load_m",   32'(load_m), 32'd20);

    // Asynchronous reset mid-edit discards the edit
    cur_h = 5'd3; cur_m = 6'd4; cur_s = 6'd5;
    press_set(); press_set();
    for (int i = 0; i < 5; i++) press_inc();
    cyc(1);
    reset_n = 1'b0; #1;
    chk("t6_sel",    32'(select), 32'd3);
    chk("t6_run_en", 32'(run_en), 32'd1);
    chk("t6_load",   32'(load),   32'd0);
    cyc(1); reset_n = 1'b1; cyc(3);
    chk("t6_load_h", 32'(load_h), 32'd0);
    chk("t6_load_m", 32'(load_m), 32'd0);
    chk("t6_load_s", 32'(load_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
